// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n
// N-channel arbiter that sits between per-client caches (I-cache, D-cache,
// prefetch/victim buffers) and the single cacheline adaptor. It serves one
// full-line transaction at a time. The winner is chosen by round-robin
// (RR_MODE=1) or by fixed priority with channel 0 highest (RR_MODE=0).
//
// Handshake: a client raises ch_read and/or ch_write together with a stable
// address and write line. It holds the request until its ch_resp bit pulses
// for one cycle. Downstream, mem_read/mem_write stay high with stable
// address/data until mem_resp pulses for one cycle. mem_resp outside BUSY has
// no meaning and is ignored.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ch_read/write   per-channel line read/write request (NUM_CH bits)
//   ch_address      packed per-channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata        packed per-channel write lines, channel i at [i*LINE_W +: LINE_W]
//   ch_rdata        read line broadcast to all channels (passthrough of mem_rdata)
//   ch_resp         one-hot completion pulse for the served channel
//   mem_*           registered downstream request, plus mem_rdata/mem_resp return
//   grant           index of the channel being served, valid while busy
//   busy            a transaction is outstanding
//   dbg_state       FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mem_arbiter_n #(
  parameter int NUM_CH  = 2,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 1,
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  output logic [GW-1:0]            grant,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] pending;
  logic              any_pending;
  logic [GW-1:0]     last;
  logic [GW-1:0]     win;
  logic [GW-1:0]     cand;

  assign pending     = ch_read | ch_write;
  assign any_pending = |pending;
  assign ch_rdata    = mem_rdata;
  assign dbg_state   = state;

  // Winner selection. Both loops walk from the least preferred candidate to
  // the most preferred one, so the last hit is the winner.
  always_comb begin
    win  = '0;
    cand = '0;
    if (RR_MODE != 0) begin
      // Search order last+1, last+2, ... modulo NUM_CH.
      for (int k = NUM_CH; k >= 1; k--) begin
        cand = GW'((int'(last) + k) % NUM_CH);
        if (pending[cand]) win = cand;
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (pending[k]) win = GW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pending) state_nxt = BUSY;
      BUSY:    if (mem_resp)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream request register. Everything the adaptor sees is captured at
  // the grant edge, so later changes on ch_* cannot disturb a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      last        <= GW'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            grant       <= win;
            mem_address <= ch_address[win*ADDR_W +: ADDR_W];
            mem_wdata   <= ch_wdata[win*LINE_W +: LINE_W];
            // A channel raising both read and write is treated as a write.
            mem_write   <= ch_write[win];
            mem_read    <= ch_read[win] & ~ch_write[win];
            busy        <= 1'b1;
            if (RR_MODE != 0) last <= win;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion is forwarded in the same cycle as mem_resp, only while BUSY.
  always_comb begin
    ch_resp = '0;
    if (state == BUSY && mem_resp) ch_resp[grant] = 1'b1;
  end

  a_resp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ch_resp));
  a_rd_wr_excl:  assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n
// Directed bench for mem_arbiter_n. Three instances share clock and reset:
//   index 0: NUM_CH=2, round-robin
//   index 1: NUM_CH=2, fixed priority
//   index 2: NUM_CH=4, round-robin
// Stimulus and observed signals are kept in 3-entry arrays so the driver
// tasks work on any instance. Channel i's address in the sequences is
// 32'h1000*(i+1).
module tb_mem_arbiter_n;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [LW-1:0] WD0 = {8{32'hC0C0_0000}};
  localparam logic [LW-1:0] WD1 = {8{32'hC1C1_0001}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // per-instance stimulus
  logic [3:0]      rd     [3];
  logic [3:0]      wr     [3];
  logic [4*AW-1:0] addr   [3];
  logic [4*LW-1:0] wd     [3];
  logic            mresp  [3];
  logic [LW-1:0]   mrdata [3];

  // per-instance observations
  wire [3:0]    resp_o  [3];
  wire [LW-1:0] rdata_o [3];
  wire          mrd     [3];
  wire          mwr     [3];
  wire [AW-1:0] maddr   [3];
  wire [LW-1:0] mwd     [3];
  wire [1:0]    gnt     [3];
  wire          bsy     [3];
  wire [1:0]    st      [3];

  assign resp_o[0][3:2] = 2'b00;
  assign resp_o[1][3:2] = 2'b00;
  assign gnt[0][1]      = 1'b0;
  assign gnt[1][1]      = 1'b0;

  mem_arbiter_n #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) u_rr2 (
    .clk(clk), .rst(rst),
    .ch_read(rd[0][1:0]), .ch_write(wr[0][1:0]),
    .ch_address(addr[0][2*AW-1:0]), .ch_wdata(wd[0][2*LW-1:0]),
    .ch_rdata(rdata_o[0]), .ch_resp(resp_o[0][1:0]),
    .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_address(maddr[0]),
    .mem_wdata(mwd[0]), .mem_rdata(mrdata[0]), .mem_resp(mresp[0]),
    .grant(gnt[0][0:0]), .busy(bsy[0]), .dbg_state(st[0])
  );

  mem_arbiter_n #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) u_fp2 (
    .clk(clk), .rst(rst),
    .ch_read(rd[1][1:0]), .ch_write(wr[1][1:0]),
    .ch_address(addr[1][2*AW-1:0]), .ch_wdata(wd[1][2*LW-1:0]),
    .ch_rdata(rdata_o[1]), .ch_resp(resp_o[1][1:0]),
    .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_address(maddr[1]),
    .mem_wdata(mwd[1]), .mem_rdata(mrdata[1]), .mem_resp(mresp[1]),
    .grant(gnt[1][0:0]), .busy(bsy[1]), .dbg_state(st[1])
  );

  mem_arbiter_n #(.NUM_CH(4), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) u_rr4 (
    .clk(clk), .rst(rst),
    .ch_read(rd[2]), .ch_write(wr[2]),
    .ch_address(addr[2]), .ch_wdata(wd[2]),
    .ch_rdata(rdata_o[2]), .ch_resp(resp_o[2]),
    .mem_read(mrd[2]), .mem_write(mwr[2]), .mem_address(maddr[2]),
    .mem_wdata(mwd[2]), .mem_rdata(mrdata[2]), .mem_resp(mresp[2]),
    .grant(gnt[2]), .busy(bsy[2]), .dbg_state(st[2])
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 2 time units after
  // the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete transaction on instance d with requests held by the caller.
  // mem_resp is returned 3 cycles after the request appears downstream.
  // exp_gap >= 0 checks how many cycles mem_read/mem_write stayed low before
  // the request appeared. Returns in the DONE cycle.
  task automatic run_txn(input int d, input int exp_g, input int exp_gap, input logic exp_w);
    int n;
    n = 0;
    while (!(mrd[d] | mwr[d]) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: dut %0d got no request within 20 cycles, expected grant %0d", d, exp_g);
      return;
    end
    if (exp_gap >= 0) chk($sformatf("d%0d_gap", d), LW'(n), LW'(exp_gap));
    chk($sformatf("d%0d_grant", d), gnt[d], LW'(exp_g));
    chk($sformatf("d%0d_mem_write", d), mwr[d], exp_w);
    chk($sformatf("d%0d_mem_read", d), mrd[d], !exp_w);
    chk($sformatf("d%0d_mem_address", d), maddr[d], 32'h1000 * (exp_g + 1));
    step();
    step();
    step();
    mresp[d]  = 1'b1;
    mrdata[d] = {8{32'hD00D_0000 + 32'(exp_g)}};
    #1;
    chk($sformatf("d%0d_ch_resp", d), resp_o[d], 4'b0001 << exp_g);
    chk($sformatf("d%0d_ch_rdata", d), rdata_o[d], {8{32'hD00D_0000 + 32'(exp_g)}});
    step();
    mresp[d] = 1'b0;
    chk($sformatf("d%0d_done_clear", d), {mrd[d], mwr[d], bsy[d]}, 3'b000);
  endtask

  // table of single arbitration decisions for the 2-channel round-robin
  // instance, starting from reset (last pointer at channel 1)
  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    int          g;
    logic        er;
    logic        ew;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_a;
    logic [LW-1:0] exp_wd;

    tbl[0] = '{2'b01, 2'b00, 32'h1000, 32'h2000, 0, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 2'b00, 32'h1010, 32'h2010, 1, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 2'b00, 32'h1020, 32'h2020, 0, 1'b1, 1'b0};
    tbl[3] = '{2'b00, 2'b01, 32'h1030, 32'h2030, 0, 1'b0, 1'b1};
    tbl[4] = '{2'b01, 2'b01, 32'h1040, 32'h2040, 0, 1'b0, 1'b1};
    tbl[5] = '{2'b10, 2'b00, 32'h1050, 32'h2050, 1, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 2'b10, 32'h1060, 32'h2060, 1, 1'b0, 1'b1};
    tbl[7] = '{2'b01, 2'b10, 32'h1070, 32'h2070, 0, 1'b1, 1'b0};
    tbl[8] = '{2'b01, 2'b10, 32'h1080, 32'h2080, 1, 1'b0, 1'b1};

    for (int d = 0; d < 3; d++) begin
      rd[d]     = '0;
      wr[d]     = '0;
      addr[d]   = '0;
      wd[d]     = '0;
      mresp[d]  = 1'b0;
      mrdata[d] = '0;
    end
    wd[0][LW-1:0]    = WD0;
    wd[0][2*LW-1:LW] = WD1;

    // reset state of every instance
    do_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_outs", d), {mrd[d], mwr[d], bsy[d], gnt[d], resp_o[d], st[d]}, '0);
      chk($sformatf("rst%0d_address", d), maddr[d], '0);
      chk($sformatf("rst%0d_wdata", d), mwd[d], '0);
    end

    // single read with exact cycle numbering; cycle 0 is now
    rd[0] = 4'b0001;
    addr[0][31:0] = 32'h0000_1000;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 2) addr[0][31:0] = 32'hDEAD_0000;
      chk($sformatf("single_c%0d_read", c), mrd[0], 1'b1);
      chk($sformatf("single_c%0d_address", c), maddr[0], 32'h0000_1000);
    end
    mresp[0]  = 1'b1;
    mrdata[0] = {32{8'hA5}};
    #1;
    chk("single_ch_resp", resp_o[0], 4'b0001);
    chk("single_ch_rdata", rdata_o[0], {32{8'hA5}});
    step();
    mresp[0] = 1'b0;
    rd[0]    = '0;
    chk("single_c6_read", mrd[0], 1'b0);
    chk("single_c6_state", st[0], 2'd2);
    step();
    chk("single_c7_state", st[0], 2'd0);

    // reset during BUSY after ch0 was last served: abandoned, and ch0 wins next
    rd[0] = 4'b0001;
    addr[0][31:0] = 32'h0000_3000;
    step();
    chk("rstmid_issue", mrd[0], 1'b1);
    step();
    rst   = 1'b1;
    rd[0] = '0;
    step();
    rst = 1'b0;
    chk("rstmid_after", {mrd[0], mwr[0], bsy[0], st[0]}, 5'b0);
    mresp[0] = 1'b1;
    #1;
    chk("rstmid_late_resp", resp_o[0], 4'b0000);
    step();
    mresp[0] = 1'b0;
    chk("rstmid_still_idle", {mrd[0], bsy[0], st[0]}, 4'b0);
    rd[0] = 4'b0011;
    step();
    chk("rstmid_next_grant", gnt[0], 2'd0);
    step();
    mresp[0] = 1'b1;
    #1;
    chk("rstmid_next_resp", resp_o[0], 4'b0001);
    step();
    mresp[0] = 1'b0;
    rd[0]    = '0;
    step();

    // table-driven arbitration vectors
    do_reset();
    for (int i = 0; i < 9; i++) begin
      rd[0][1:0]    = tbl[i].rd;
      wr[0][1:0]    = tbl[i].wr;
      addr[0][31:0]  = tbl[i].a0;
      addr[0][63:32] = tbl[i].a1;
      exp_a  = (tbl[i].g == 0) ? tbl[i].a0 : tbl[i].a1;
      exp_wd = (tbl[i].g == 0) ? WD0 : WD1;
      step();
      chk($sformatf("tbl%0d_grant", i), gnt[0], LW'(tbl[i].g));
      chk($sformatf("tbl%0d_mem_read", i), mrd[0], tbl[i].er);
      chk($sformatf("tbl%0d_mem_write", i), mwr[0], tbl[i].ew);
      chk($sformatf("tbl%0d_mem_address", i), maddr[0], exp_a);
      chk($sformatf("tbl%0d_mem_wdata", i), mwd[0], exp_wd);
      chk($sformatf("tbl%0d_busy_state", i), {bsy[0], st[0]}, 3'b101);
      step();
      step();
      mresp[0]  = 1'b1;
      mrdata[0] = {8{32'h0F0F_0000 + 32'(i)}};
      #1;
      chk($sformatf("tbl%0d_ch_resp", i), resp_o[0], 4'b0001 << tbl[i].g);
      chk($sformatf("tbl%0d_ch_rdata", i), rdata_o[0], {8{32'h0F0F_0000 + 32'(i)}});
      step();
      mresp[0] = 1'b0;
      rd[0]    = '0;
      wr[0]    = '0;
      chk($sformatf("tbl%0d_done", i), {mrd[0], mwr[0], bsy[0], st[0]}, 5'b00010);
      step();
    end

    // both channels pending continuously on round-robin: 0,1,0,1 with a
    // DONE cycle and an arbitration cycle between transactions
    addr[0][31:0]  = 32'h1000;
    addr[0][63:32] = 32'h2000;
    rd[0] = 4'b0011;
    run_txn(0, 0, -1, 1'b0);
    run_txn(0, 1, 2, 1'b0);
    run_txn(0, 0, 2, 1'b0);
    run_txn(0, 1, 2, 1'b0);
    rd[0] = '0;
    step();
    step();

    // fixed priority: ch0 read always wins while pending; ch1 write waits
    addr[1][31:0]    = 32'h1000;
    addr[1][63:32]   = 32'h2000;
    wd[1][LW-1:0]    = WD0;
    wd[1][2*LW-1:LW] = WD1;
    rd[1] = 4'b0001;
    wr[1] = 4'b0010;
    run_txn(1, 0, -1, 1'b0);
    run_txn(1, 0, 2, 1'b0);
    run_txn(1, 0, 2, 1'b0);
    rd[1] = '0;
    run_txn(1, 1, 2, 1'b1);
    chk("fp_ch1_wdata", mwd[1], WD1);
    wr[1] = '0;
    step();
    step();

    // four channels round-robin, all pending
    addr[2] = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    rd[2]   = 4'hF;
    do_reset();
    run_txn(2, 0, -1, 1'b0);
    run_txn(2, 1, 2, 1'b0);
    run_txn(2, 2, 2, 1'b0);
    run_txn(2, 3, 2, 1'b0);
    run_txn(2, 0, 2, 1'b0);

    // same again with ch2 dropping out after ch1 is served
    do_reset();
    run_txn(2, 0, -1, 1'b0);
    run_txn(2, 1, 2, 1'b0);
    rd[2][2] = 1'b0;
    run_txn(2, 3, 2, 1'b0);
    run_txn(2, 0, 2, 1'b0);
    rd[2] = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-channel arbiter between per-client caches (I-cache, D-cache, and any future prefetch or victim buffers) and the single cacheline adaptor.
- Successor to the fixed two-channel I/D arbiter.
- Adds a configurable channel count, configurable line and address widths, round-robin or fixed-priority selection, and registered downstream outputs.
- Serves exactly one full-line transaction at a time.

Parameters:
- NUM_CH, 2: number of client channels, 2..8.
- LINE_W, 256: cacheline width in bits.
- ADDR_W, 32: address width.
- RR_MODE, 1: 1 selects round-robin; 0 selects fixed priority, with channel 0 highest.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_read  in  NUM_CH  per-channel line read request; held high until that channel's ch_resp.
- ch_write  in  NUM_CH  per-channel line write request; held high until that channel's ch_resp.
- ch_address  in  NUM_CH*ADDR_W  per-channel line address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line; channel i occupies bits [i*LINE_W +: LINE_W].
- ch_rdata  out  LINE_W  read line, broadcast to all channels.
- ch_resp  out  NUM_CH  one-hot completion pulse.
- mem_read  out  1  downstream read request.
- mem_write  out  1  downstream write request.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write line.
- mem_rdata  in  LINE_W  downstream read line.
- mem_resp  in  1  downstream completion pulse.
- grant  out  $clog2(NUM_CH)  index of the channel being served; valid while busy is high.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst high at a clk edge):
  - state becomes IDLE.
  - mem_read, mem_write, busy become 0.
  - mem_address, mem_wdata, grant become 0.
  - Round-robin pointer last becomes NUM_CH-1, so channel 0 wins first.
  - ch_resp is 0 while in IDLE.
- Reset mid-transaction:
  - The transaction is abandoned and no ch_resp is issued.
  - mem_read and mem_write are low from the following cycle.
  - A mem_resp arriving afterwards is ignored.
- Definition: pending[i] = ch_read[i] | ch_write[i].
- IDLE, when any pending bit is set:
  - Select winner w.
    - RR_MODE=1: first pending channel searching last+1, last+2, … modulo NUM_CH.
    - RR_MODE=0: lowest pending index.
  - On the edge, register:
    - grant <= w.
    - mem_address <= ch_address[w].
    - mem_wdata <= ch_wdata[w].
    - mem_write <= ch_write[w].
    - mem_read <= ch_read[w] & ~ch_write[w]; if a channel asserts both, the write wins.
    - busy <= 1; last <= w (RR_MODE=1 only).
  - Go to BUSY.
- Latency: a request sampled in IDLE at edge k appears on mem_read/mem_write during the cycle after edge k.
- BUSY:
  - Downstream outputs are held stable.
  - ch_resp[grant] = mem_resp, combinationally, in the same cycle; all other ch_resp bits are 0.
  - ch_rdata = mem_rdata at all times, combinational passthrough.
  - On mem_resp: clear mem_read, mem_write, busy; go to DONE.
  - Requests from other channels stay pending and are not lost.
- DONE:
  - One dead cycle so the served client can drop its request.
  - Requests are not sampled; go to IDLE.
  - Back-to-back service therefore costs 1 arbitration cycle + 1 DONE cycle of overhead.
- Fairness: in round-robin mode, a continuously pending channel is granted within NUM_CH-1 other transactions. In fixed mode, lower channels may starve higher ones; this is intended.
- Request changes: a change in ch_address or ch_wdata after the grant has no effect, because the values are registered.
- Spurious responses: mem_resp seen in IDLE or DONE is ignored, and no ch_resp is produced.
- NUM_CH=1 degenerates to a registered pass-through; grant is held at 0.
- No combinational path from ch_* inputs to mem_* outputs.
- Simulation assertions:
  - $onehot0(ch_resp).
  - mem_read & mem_write never both high.

Test Plan:
- Single read, NUM_CH=2, RR: ch_read=2'b01, ch_address[0]=32'h0000_1000 at cycle 0; mem_resp at cycle 5 with mem_rdata=256'hA5…A5.
  - Required: mem_read=1 and mem_address=32'h1000 from cycle 1 to cycle 5.
  - Required: ch_resp=2'b01 in cycle 5 and ch_rdata=256'hA5…A5.
  - Required: mem_read=0 in cycle 6; state IDLE in cycle 7.
- Simultaneous requests, RR: ch_read=2'b11 held throughout; mem_resp 3 cycles after each request.
  - Required grant order 0, 1, 0, …; the second request is issued 2 cycles after the first response.
- Fixed priority, RR_MODE=0: both channels request continuously; ch1 write of addr 32'h2000.
  - Required: ch0 is served every time; ch1 is never granted while ch0 is pending.
  - Required: ch1 is granted at the first IDLE in which ch0 is idle; mem_write=1, mem_address=32'h2000, mem_wdata=ch_wdata[1].
- Read and write together on ch0: ch_read=ch_write=1 -> required mem_write=1, mem_read=0.
- Reset mid-transaction: rst for 1 cycle during BUSY, then mem_resp.
  - Required: mem_read=0 and busy=0 from the cycle after rst; ch_resp stays 0.
  - Required: the next request goes to ch0 first.
- NUM_CH=4, RR: all four channels requesting continuously.
  - Required grant sequence 0,1,2,3,0; ch_resp is one-hot each time.
  - Required: ch2 dropping its request mid-sequence yields the order 0,1,3,0.
